// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller driving a req/ack data bus
module mem_access_unit #(
   parameter int TIMEOUT   = 255,
   parameter int TIMEOUT_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exmem_mem_r,
   input  logic        exmem_mem_w,
   input  logic [2:0]  exmem_mem_type,
   input  logic [31:0] exmem_addr,
   input  logic [31:0] exmem_rt_data,
   input  logic        dbus_ack,
   input  logic [31:0] dbus_rdata,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   output logic [3:0]  dbus_be,
   output logic [31:0] mem_data,
   output logic        mem_stall,
   output logic        addr_err,
   output logic        bus_err
);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2;
   logic [1:0]           state;
   logic [TIMEOUT_W-1:0] count;
   logic                 ld;
   logic [2:0]           ld_type;
   logic [1:0]           ld_off;
   logic                 is_byte, is_half, access;
   logic [3:0]           be;
   logic [31:0]          wdata, rdata_fmt;
   logic [7:0]           rbyte;
   logic [15:0]          rhalf;
   always_comb begin
      is_byte   = exmem_mem_type[1:0] == 2'b00;
      is_half   = exmem_mem_type[1:0] == 2'b01;
      addr_err  = (exmem_mem_r | exmem_mem_w) & (is_half ? exmem_addr[0] : !is_byte & |exmem_addr[1:0]);
      access    = (exmem_mem_r | exmem_mem_w) & !addr_err;
      mem_stall = state == REQ || (state == IDLE && access);
      be        = is_byte ? 4'b0001 << exmem_addr[1:0] : is_half ? (exmem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata     = is_byte ? {4{exmem_rt_data[7:0]}} : is_half ? {2{exmem_rt_data[15:0]}} : exmem_rt_data;
      rbyte     = dbus_rdata[{ld_off, 3'b000} +: 8];
      rhalf     = dbus_rdata[{ld_off[1], 4'b0000} +: 16];
      // type bit 2 selects zero extension for byte/half loads
      rdata_fmt = ld_type[1:0] == 2'b00 ? {{24{!ld_type[2] & rbyte[7]}}, rbyte} :
                  ld_type[1:0] == 2'b01 ? {{16{!ld_type[2] & rhalf[15]}}, rhalf} : dbus_rdata;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         ld         <= 1'b0;
         ld_type    <= 3'b000;
         ld_off     <= 2'b00;
         dbus_req   <= 1'b0;
         dbus_we    <= 1'b0;
         dbus_addr  <= '0;
         dbus_wdata <= '0;
         dbus_be    <= 4'b0000;
         mem_data   <= '0;
         bus_err    <= 1'b0;
      end else begin
         bus_err <= 1'b0;
         case (state)
            IDLE: if (access) begin
               state      <= REQ;
               count      <= '0;
               dbus_req   <= 1'b1;
               dbus_we    <= exmem_mem_w;
               dbus_addr  <= {exmem_addr[31:2], 2'b00};
               dbus_be    <= be;
               dbus_wdata <= wdata;
               ld         <= exmem_mem_r & !exmem_mem_w;
               ld_type    <= exmem_mem_type;
               ld_off     <= exmem_addr[1:0];
            end
            REQ: if (dbus_ack) begin
               if (ld) mem_data <= rdata_fmt;
               dbus_req <= 1'b0;
               state    <= DONE;
            end else if (count == TIMEOUT_W'(TIMEOUT)) begin
               if (ld) mem_data <= '0;
               bus_err  <= 1'b1;
               dbus_req <= 1'b0;
               state    <= DONE;
            end else begin
               count <= count + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed checks against a behavioural model
module tb_mem_access_unit;
   logic        clk = 0, reset = 1;
   logic        exmem_mem_r = 0, exmem_mem_w = 0;
   logic [2:0]  exmem_mem_type = 0;
   logic [31:0] exmem_addr = 0, exmem_rt_data = 0;
   logic        dbus_ack = 0;
   logic [31:0] dbus_rdata = 0;
   logic        dbus_req, dbus_we, mem_stall, addr_err, bus_err;
   logic [31:0] dbus_addr, dbus_wdata, mem_data;
   logic [3:0]  dbus_be;
   int          checks = 0, failures = 0;
   logic [31:0] exp_md = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
      .clk(clk), .reset(reset), .exmem_mem_r(exmem_mem_r), .exmem_mem_w(exmem_mem_w),
      .exmem_mem_type(exmem_mem_type), .exmem_addr(exmem_addr), .exmem_rt_data(exmem_rt_data),
      .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .dbus_req(dbus_req), .dbus_we(dbus_we),
      .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .mem_data(mem_data),
      .mem_stall(mem_stall), .addr_err(addr_err), .bus_err(bus_err)
   );

   function automatic int size_of(logic [2:0] t);
      return (t == 3'd0 || t == 3'd4) ? 1 : (t == 3'd1 || t == 3'd5) ? 2 : 4;
   endfunction

   function automatic logic [31:0] fmt(logic [2:0] t, logic [31:0] a, logic [31:0] rd);
      longint b = longint'(rd >> (8 * (a % 4))) % 256;
      longint h = longint'(rd >> (16 * ((a % 4) / 2))) % 65536;
      if (t == 3'd0) return 32'(b >= 128 ? b - 256 : b);
      if (t == 3'd4) return 32'(b);
      if (t == 3'd1) return 32'(h >= 32768 ? h - 65536 : h);
      if (t == 3'd5) return 32'(h);
      return rd;
   endfunction

   task automatic run_access(input logic r, w, input logic [2:0] t, input logic [31:0] a, rt, rd,
                             input int waits, output int stalls, output logic ae, req_seen, berr,
                             output logic we, output logic [3:0] be, output logic [31:0] ad, wd, md);
      int  n = 0;
      bit  done = 0;
      @(negedge clk);
      exmem_mem_r = r; exmem_mem_w = w; exmem_mem_type = t; exmem_addr = a; exmem_rt_data = rt;
      dbus_ack = 0;
      stalls = 0; req_seen = 0; berr = 0; ae = 0; we = 0; be = 0; ad = 0; wd = 0; md = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         #1;
         if (c == 0) ae = addr_err;
         if (mem_stall) stalls++;
         if (bus_err) berr = 1;
         if (dbus_req) begin
            if (!req_seen) begin we = dbus_we; be = dbus_be; ad = dbus_addr; wd = dbus_wdata; end
            req_seen = 1;
            dbus_ack = (n == waits);
            dbus_rdata = dbus_ack ? rd : $urandom;
            n++;
         end else dbus_ack = 0;
         if (!mem_stall) begin done = 1; md = mem_data; end
         else @(negedge clk);
      end
      exmem_mem_r = 0; exmem_mem_w = 0; dbus_ack = 0;
   endtask

   task automatic test_reset;
      reset = 1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if ({dbus_req, dbus_we, dbus_be, bus_err, mem_stall, addr_err} !== 9'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=0", {dbus_req, dbus_we, dbus_be, bus_err, mem_stall, addr_err}); end
      checks++; if ({dbus_addr, dbus_wdata, mem_data} !== 96'b0) begin
         failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", dbus_addr, dbus_wdata, mem_data); end
      reset = 0;
   endtask

   task automatic test_lb;
      int s; logic ae, rs, be_, we; logic [3:0] be; logic [31:0] ad, wd, md;
      run_access(1, 0, 3'd0, 32'h1003, 0, 32'h80FF_1234, 0, s, ae, rs, be_, we, be, ad, wd, md);
      exp_md = 32'hFFFF_FF80;
      checks++; if (md !== exp_md) begin failures++; $display("FAIL lb_data got=%h exp=%h", md, exp_md); end
      checks++; if (s !== 2) begin failures++; $display("FAIL lb_stall got=%0d exp=2", s); end
      checks++; if (ad !== 32'h1000) begin failures++; $display("FAIL lb_addr got=%h exp=00001000", ad); end
   endtask

   task automatic test_lhu_wait;
      int s; logic ae, rs, be_, we; logic [3:0] be; logic [31:0] ad, wd, md;
      run_access(1, 0, 3'd5, 32'h2002, 0, 32'h8001_0000, 3, s, ae, rs, be_, we, be, ad, wd, md);
      exp_md = 32'h0000_8001;
      checks++; if (md !== exp_md) begin failures++; $display("FAIL lhu_data got=%h exp=%h", md, exp_md); end
      checks++; if (s !== 5) begin failures++; $display("FAIL lhu_stall got=%0d exp=5", s); end
   endtask

   task automatic test_sb;
      int s; logic ae, rs, be_, we; logic [3:0] be; logic [31:0] ad, wd, md;
      run_access(0, 1, 3'd0, 32'h0101, 32'h1234_56AB, 0, 0, s, ae, rs, be_, we, be, ad, wd, md);
      checks++; if (we !== 1 || be !== 4'b0010) begin failures++; $display("FAIL sb_we_be got=%b/%b exp=1/0010", we, be); end
      checks++; if (wd !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_wdata got=%h exp=ababab ab", wd); end
      checks++; if (ad !== 32'h100) begin failures++; $display("FAIL sb_addr got=%h exp=00000100", ad); end
      checks++; if (md !== exp_md) begin failures++; $display("FAIL sb_md got=%h exp=%h", md, exp_md); end
   endtask

   task automatic test_misaligned;
      int s; logic ae, rs, be_, we; logic [3:0] be; logic [31:0] ad, wd, md;
      run_access(1, 0, 3'd2, 32'h0006, 0, 32'h5555_5555, 0, s, ae, rs, be_, we, be, ad, wd, md);
      checks++; if (ae !== 1) begin failures++; $display("FAIL lw_misalign_err got=%b exp=1", ae); end
      checks++; if (rs !== 0 || s !== 0) begin failures++; $display("FAIL lw_misalign_bus got req=%b stall=%0d exp 0/0", rs, s); end
      checks++; if (md !== exp_md) begin failures++; $display("FAIL lw_misalign_md got=%h exp=%h", md, exp_md); end
   endtask

   task automatic test_timeout;
      int s; logic ae, rs, berr, we; logic [3:0] be; logic [31:0] ad, wd, md;
      run_access(1, 0, 3'd2, 32'h0040, 0, 0, 1000, s, ae, rs, berr, we, be, ad, wd, md);
      exp_md = 0;
      checks++; if (s !== 6) begin failures++; $display("FAIL to_stall got=%0d exp=6", s); end
      checks++; if (berr !== 1 || md !== 0) begin failures++; $display("FAIL to_err got=%b md=%h exp 1/0", berr, md); end
      @(negedge clk); #1;
      checks++; if (bus_err !== 0) begin failures++; $display("FAIL to_pulse got=%b exp=0", bus_err); end
      run_access(1, 0, 3'd2, 32'h0044, 0, 32'hCAFE_F00D, 1, s, ae, rs, berr, we, be, ad, wd, md);
      exp_md = 32'hCAFE_F00D;
      checks++; if (md !== exp_md || s !== 3) begin failures++; $display("FAIL to_next got=%h/%0d exp=%h/3", md, s, exp_md); end
   endtask

   task automatic test_reset_mid_op;
      @(negedge clk);
      exmem_mem_r = 1; exmem_mem_type = 3'd2; exmem_addr = 32'h80;
      @(negedge clk); #1;
      checks++; if (dbus_req !== 1) begin failures++; $display("FAIL rst_mid_req got=%b exp=1", dbus_req); end
      reset = 1;
      @(negedge clk);
      reset = 0; exmem_mem_r = 0;
      #1;
      exp_md = 0;
      checks++; if (dbus_req !== 0 || mem_stall !== 0) begin failures++; $display("FAIL rst_mid_idle got req=%b stall=%b exp 0/0", dbus_req, mem_stall); end
      dbus_ack = 1; dbus_rdata = 32'hDEAD_BEEF;
      repeat (2) @(negedge clk);
      dbus_ack = 0; #1;
      checks++; if (mem_data !== exp_md || dbus_req !== 0) begin failures++; $display("FAIL rst_mid_ack got md=%h req=%b exp %h/0", mem_data, dbus_req, exp_md); end
   endtask

   task automatic test_random;
      for (int i = 0; i < 60; i++) begin
         int s, sz, waits; logic ae, rs, berr, we; logic [3:0] be; logic [31:0] ad, wd, md;
         logic r, w, err, act; logic [2:0] t; logic [31:0] a, rt, rd, e_wd; logic [3:0] e_be;
         r = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
         t = 3'($urandom_range(0, 7)); a = $urandom; rt = $urandom; rd = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         waits = $urandom_range(0, 3);
         sz = size_of(t);
         err = (r | w) && (a % sz != 0);
         act = (r | w) && !err;
         e_be = 4'(((1 << sz) - 1) << (a % 4));
         e_wd = sz == 1 ? {24'b0, rt[7:0]} * 32'h0101_0101 : sz == 2 ? {16'b0, rt[15:0]} * 32'h0001_0001 : rt;
         run_access(r, w, t, a, rt, rd, waits, s, ae, rs, berr, we, be, ad, wd, md);
         if (act && r && !w) exp_md = fmt(t, a, rd);
         checks++; if (ae !== err) begin failures++; $display("FAIL rnd%0d_aerr got=%b exp=%b", i, ae, err); end
         checks++; if (s !== (act ? 2 + waits : 0)) begin failures++; $display("FAIL rnd%0d_stall got=%0d exp=%0d", i, s, act ? 2 + waits : 0); end
         checks++; if (md !== exp_md) begin failures++; $display("FAIL rnd%0d_md got=%h exp=%h t=%0d a=%h", i, md, exp_md, t, a); end
         if (act) begin
            checks++; if (ad !== a - a % 4 || we !== w || be !== e_be) begin
               failures++; $display("FAIL rnd%0d_bus got addr=%h we=%b be=%b exp %h/%b/%b", i, ad, we, be, a - a % 4, w, e_be); end
            if (w) begin
               checks++; if (wd !== e_wd) begin failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, wd, e_wd); end
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_lb;
      test_lhu_wait;
      test_sb;
      test_misaligned;
      test_timeout;
      test_reset_mid_op;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
